// File: rtl/mem_req_queue.sv
// mem_req_queue: data-memory request unit between EXE and MEM.
// A one-entry hold register feeds a req/addr_ok/data_ok bus. An in-order
// FIFO tracks issued and misaligned requests so that responses return in
// program order. A flush marks every tracked entry as discard.
module mem_req_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [1:0]          in_size,
  input  logic                in_wr,
  input  logic                in_unsigned,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                flush,
  output logic                req,
  output logic                req_wr,
  output logic [1:0]          req_size,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]   req_wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                rsp_valid,
  output logic                rsp_wr,
  output logic                rsp_ale,
  output logic [DATA_W-1:0]   rsp_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // What the response path needs to know about each tracked request.
  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [1:0]       size;
    logic             wr;
    logic             uns;
    logic             ale;
  } ord_t;

  logic              hold_v, hold_wr, hold_uns, hold_ale;
  logic [ADDR_W-1:0] hold_addr;
  logic [1:0]        hold_size;
  logic [DATA_W-1:0] hold_wdata;

  ord_t              ord_q [DEPTH];
  logic [DEPTH-1:0]  disc_q;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              in_ale, not_full, issue, hold_drain, accept, push, pop;
  ord_t              head;
  logic              head_disc, rsp_fire;
  logic [STRB_W-1:0] strb_base;
  logic [DATA_W-1:0] wdata_rep, shifted, mask, load_ext;
  logic              sign;

  assign not_full   = count < CNT_W'(DEPTH);
  assign req        = hold_v & ~hold_ale & not_full;
  assign issue      = req & addr_ok;
  assign hold_drain = issue | (hold_v & hold_ale & not_full);
  assign in_ready   = ~flush & (~hold_v | hold_drain);
  assign accept     = in_valid & in_ready;
  // During a flush only an entry the memory has just taken must be tracked.
  assign push       = flush ? issue : hold_drain;
  assign head       = ord_q[rd_ptr];
  assign head_disc  = disc_q[rd_ptr];
  // A misaligned head never sees data_ok, so it retires as soon as it is head.
  assign pop        = (count != '0) & (head.ale | data_ok);
  assign rsp_fire   = pop & ~head_disc & ~flush;

  assign req_wr     = hold_wr;
  assign req_size   = hold_size;
  assign req_addr   = hold_addr;
  assign req_wdata  = wdata_rep;

  // Flag misaligned requests as they are accepted.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    in_ale = 1'b0;
    case (in_size)
      2'd1:    in_ale = in_addr[0];
      2'd2:    in_ale = |in_addr[1:0];
      2'd3:    in_ale = (DATA_W == 32) | (|in_addr[2:0]);
      default: in_ale = 1'b0;
    endcase
  end

  // Byte strobes and replicated store data for the held request.
  always_comb begin
    strb_base = '1;
    wdata_rep = hold_wdata;
    case (hold_size)
      2'd0: begin
        strb_base = STRB_W'(1);
        wdata_rep = {STRB_W{hold_wdata[7:0]}};
      end
      2'd1: begin
        strb_base = STRB_W'(3);
        wdata_rep = {(DATA_W/16){hold_wdata[15:0]}};
      end
      2'd2: begin
        strb_base = STRB_W'(4'hF);
        wdata_rep = {(DATA_W/32){hold_wdata[31:0]}};
      end
      default: ;
    endcase
    req_wstrb = hold_wr ? (strb_base << hold_addr[OFF_W-1:0]) : '0;
  end

  // Align the head's read data and extend it to the bus width.
  always_comb begin
    shifted = rdata >> {head.off, 3'b000};
    mask    = '1;
    sign    = 1'b0;
    case (head.size)
      2'd0: begin
        mask = DATA_W'(8'hFF);
        sign = shifted[7];
      end
      2'd1: begin
        mask = DATA_W'(16'hFFFF);
        sign = shifted[15];
      end
      2'd2: begin
        mask = DATA_W'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: ;
    endcase
    load_ext = (shifted & mask) | ({DATA_W{sign & ~head.uns}} & ~mask);
  end

  // Hold register: capture an accepted request and release it on drain or flush.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (!resetn) begin
      hold_v     <= 1'b0;
      hold_wr    <= 1'b0;
      hold_uns   <= 1'b0;
      hold_ale   <= 1'b0;
      hold_addr  <= '0;
      hold_size  <= '0;
      hold_wdata <= '0;
    end else if (flush) begin
      hold_v <= 1'b0;
    end else if (accept) begin
      hold_v     <= 1'b1;
      hold_wr    <= in_wr;
      hold_uns   <= in_unsigned;
      hold_ale   <= in_ale;
      hold_addr  <= in_addr;
      hold_size  <= in_size;
      hold_wdata <= in_wdata;
    end else if (hold_drain) begin
      hold_v <= 1'b0;
    end
  end

  // Order FIFO control: pointers, occupancy and per-entry discard flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      disc_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (flush) disc_q <= '1;
      if (push)  disc_q[wr_ptr] <= flush;
    end
  end

  // Order FIFO payload, written on every push.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is not reset; count and pointers gate every read of it.
    if (push) begin
      ord_q[wr_ptr] <= '{off:  hold_addr[OFF_W-1:0],
                         size: hold_size,
                         wr:   hold_wr,
                         uns:  hold_uns,
                         ale:  hold_ale};
    end
  end

  // Registered response: one-cycle pulse, payload held between responses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_ale   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_wr    <= head.wr;
        rsp_ale   <= head.ale;
        rsp_rdata <= (head.wr | head.ale) ? '0 : load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed testbench for mem_req_queue: a 32-bit and a 64-bit instance
// share clock, reset and bus-side controls; each has its own in_valid.
module tb_mem_req_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid32, in_valid64;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        in_wr, in_uns;
  logic [63:0] in_wdata;
  logic        flush, addr_ok, data_ok;
  logic [63:0] rdata;

  logic        in_ready32, req32, req_wr32, rsp_valid32, rsp_wr32, rsp_ale32;
  logic [1:0]  req_size32;
  logic [31:0] req_addr32, req_wdata32, rsp_rdata32;
  logic [3:0]  req_wstrb32;

  logic        in_ready64, req64, req_wr64, rsp_valid64, rsp_wr64, rsp_ale64;
  logic [1:0]  req_size64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64, rsp_rdata64;
  logic [7:0]  req_wstrb64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(2)) u32 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_addr(in_addr),
    .in_size(in_size), .in_wr(in_wr), .in_unsigned(in_uns),
    .in_wdata(in_wdata[31:0]), .flush(flush),
    .req(req32), .req_wr(req_wr32), .req_size(req_size32), .req_addr(req_addr32),
    .req_wstrb(req_wstrb32), .req_wdata(req_wdata32),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata[31:0]),
    .rsp_valid(rsp_valid32), .rsp_wr(rsp_wr32), .rsp_ale(rsp_ale32),
    .rsp_rdata(rsp_rdata32)
  );

  mem_req_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(2)) u64 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_addr(in_addr),
    .in_size(in_size), .in_wr(in_wr), .in_unsigned(in_uns),
    .in_wdata(in_wdata), .flush(flush),
    .req(req64), .req_wr(req_wr64), .req_size(req_size64), .req_addr(req_addr64),
    .req_wstrb(req_wstrb64), .req_wdata(req_wdata64),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .rsp_valid(rsp_valid64), .rsp_wr(rsp_wr64), .rsp_ale(rsp_ale64),
    .rsp_rdata(rsp_rdata64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [1:0] s, input logic w,
                         input logic u, input logic [63:0] wd);
    in_addr = a; in_size = s; in_wr = w; in_uns = u; in_wdata = wd;
  endtask

  // Single load on the 32-bit instance, data_ok one cycle after addr_ok.
  task automatic load32(input string tag, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] rd, input logic [31:0] exp);
    set_req(a, s, 1'b0, u, 64'h0);
    in_valid32 = 1'b1;
    tick();
    in_valid32 = 1'b0; addr_ok = 1'b1;
    #1 check({tag, "_req"}, req32, 1);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = {32'h0, rd};
    tick();
    data_ok = 1'b0;
    #1 check({tag, "_vld"}, rsp_valid32, 1);
    check({tag, "_data"}, rsp_rdata32, exp);
  endtask

  // Single load or store on the 64-bit instance.
  task automatic op64(input string tag, input logic [31:0] a, input logic [1:0] s,
                      input logic w, input logic u, input logic [63:0] rd,
                      input logic [63:0] exp);
    set_req(a, s, w, u, 64'h0);
    in_valid64 = 1'b1;
    tick();
    in_valid64 = 1'b0; addr_ok = 1'b1;
    #1 check({tag, "_req"}, req64, 1);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = rd;
    tick();
    data_ok = 1'b0;
    #1 check({tag, "_vld"}, rsp_valid64, 1);
    check({tag, "_data"}, rsp_rdata64, exp);
  endtask

  initial begin
    resetn = 1'b1;
    in_valid32 = 1'b0; in_valid64 = 1'b0;
    set_req(32'h0, 2'd0, 1'b0, 1'b0, 64'h0);
    flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 64'h0;

    // Reset state
    #2 resetn = 1'b0;
    #1;
    check("rst_req", req32, 0);
    check("rst_rsp_valid", rsp_valid32, 0);
    check("rst_in_ready", in_ready32, 1);
    check("rst_rsp_rdata", rsp_rdata32, 0);
    check("rst_rsp_wr_ale", {rsp_wr32, rsp_ale32}, 0);
    check("rst_req64", req64, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Aligned ld.w at 0x100, data_ok two cycles after addr_ok
    set_req(32'h100, 2'd2, 1'b0, 1'b0, 64'h0);
    in_valid32 = 1'b1;
    #1 check("ldw_in_ready", in_ready32, 1);
    check("ldw_no_req_yet", req32, 0);
    tick();
    in_valid32 = 1'b0; addr_ok = 1'b1;
    #1 check("ldw_req", req32, 1);
    check("ldw_addr", req_addr32, 32'h100);
    check("ldw_wstrb", req_wstrb32, 0);
    check("ldw_size", req_size32, 2);
    tick();
    addr_ok = 1'b0;
    #1 check("ldw_req_low", req32, 0);
    tick();
    data_ok = 1'b1; rdata = 64'h8000_00F0;
    #1 check("ldw_rsp_not_yet", rsp_valid32, 0);
    tick();
    data_ok = 1'b0;
    #1 check("ldw_rsp_valid", rsp_valid32, 1);
    check("ldw_rsp_data", rsp_rdata32, 32'h8000_00F0);
    check("ldw_rsp_wr_ale", {rsp_wr32, rsp_ale32}, 0);
    tick();
    #1 check("ldw_pulse_end", rsp_valid32, 0);
    check("ldw_data_hold", rsp_rdata32, 32'h8000_00F0);

    // st.b at 0x103
    set_req(32'h103, 2'd0, 1'b1, 1'b0, 64'h5A);
    in_valid32 = 1'b1;
    tick();
    in_valid32 = 1'b0; addr_ok = 1'b1;
    #1 check("stb_wstrb", req_wstrb32, 4'b1000);
    check("stb_wdata", req_wdata32, 32'h5A5A_5A5A);
    check("stb_wr", req_wr32, 1);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1;
    tick();
    data_ok = 1'b0;
    #1 check("stb_rsp", {rsp_valid32, rsp_wr32, rsp_ale32}, 3'b110);
    check("stb_rsp_data", rsp_rdata32, 0);

    // Byte/half loads with extension
    load32("ldb_s", 32'h103, 2'd0, 1'b0, 32'h8012_3456, 32'hFFFF_FF80);
    load32("ldb_u", 32'h103, 2'd0, 1'b1, 32'h8012_3456, 32'h0000_0080);
    load32("ldh_s", 32'h102, 2'd1, 1'b0, 32'hBEEF_0000, 32'hFFFF_BEEF);
    load32("ldh_u", 32'h100, 2'd1, 1'b1, 32'h0000_9ABC, 32'h0000_9ABC);
    tick();

    // Three loads, DEPTH=2, data_ok withheld
    set_req(32'h10, 2'd2, 1'b0, 1'b0, 64'h0);
    in_valid32 = 1'b1; addr_ok = 1'b1;
    tick();
    in_addr = 32'h14;
    #1 check("q3_ready_drain", in_ready32, 1);
    tick();
    in_addr = 32'h18;
    #1 check("q3_req_2nd", req32, 1);
    tick();
    in_valid32 = 1'b0;
    #1 check("q3_full_req", req32, 0);
    check("q3_full_ready", in_ready32, 0);
    tick();
    data_ok = 1'b1; rdata = 64'h1111_1111;
    #1 check("q3_still_held", req32, 0);
    tick();
    rdata = 64'h2222_2222;
    #1 check("q3_rsp1", rsp_rdata32, 32'h1111_1111);
    check("q3_rsp1_v", rsp_valid32, 1);
    check("q3_req3", req32, 1);
    check("q3_req3_addr", req_addr32, 32'h18);
    tick();
    rdata = 64'h3333_3333;
    #1 check("q3_rsp2", rsp_rdata32, 32'h2222_2222);
    check("q3_hold_empty", req32, 0);
    tick();
    data_ok = 1'b0; addr_ok = 1'b0;
    #1 check("q3_rsp3", {31'h0, rsp_valid32, rsp_rdata32}, {31'h0, 1'b1, 32'h3333_3333});
    tick();
    #1 check("q3_idle", rsp_valid32, 0);

    // Misaligned ld.w between two aligned loads
    set_req(32'h20, 2'd2, 1'b0, 1'b0, 64'h0);
    in_valid32 = 1'b1; addr_ok = 1'b1;
    tick();
    in_addr = 32'h102;
    tick();
    in_addr = 32'h24;
    #1 check("ale_no_req", req32, 0);
    check("ale_ready", in_ready32, 1);
    tick();
    in_valid32 = 1'b0; data_ok = 1'b1; rdata = 64'hAAAA_0000;
    #1 check("ale_full", req32, 0);
    tick();
    data_ok = 1'b0;
    #1 check("ale_rsp1", {rsp_valid32, rsp_ale32, rsp_rdata32}, {2'b10, 32'hAAAA_0000});
    check("ale_req3_addr", {req32, req_addr32}, {1'b1, 32'h24});
    tick();
    data_ok = 1'b1; rdata = 64'h0000_CCCC;
    #1 check("ale_rsp2", {rsp_valid32, rsp_ale32, rsp_rdata32}, {2'b11, 32'h0});
    tick();
    data_ok = 1'b0; addr_ok = 1'b0;
    #1 check("ale_rsp3", {rsp_valid32, rsp_ale32, rsp_rdata32}, {2'b10, 32'h0000_CCCC});
    tick();

    // Flush coincident with addr_ok of a held request
    set_req(32'h30, 2'd2, 1'b0, 1'b0, 64'h0);
    in_valid32 = 1'b1; addr_ok = 1'b1;
    tick();
    in_addr = 32'h34;
    tick();
    in_addr = 32'h38;
    tick();
    in_valid32 = 1'b0; data_ok = 1'b1; rdata = 64'h1;
    tick();
    data_ok = 1'b0; flush = 1'b1; in_valid32 = 1'b1; in_addr = 32'h3C;
    #1 check("fl_pre_rsp", rsp_valid32, 1);
    check("fl_ready", in_ready32, 0);
    check("fl_req", {req32, req_addr32}, {1'b1, 32'h38});
    tick();
    flush = 1'b0; in_valid32 = 1'b0; addr_ok = 1'b0; data_ok = 1'b1;
    #1 check("fl_hold_clear", req32, 0);
    check("fl_no_rsp0", rsp_valid32, 0);
    tick();
    #1 check("fl_no_rsp1", rsp_valid32, 0);
    tick();
    #1 check("fl_no_rsp2", rsp_valid32, 0);
    tick();
    data_ok = 1'b0;
    #1 check("fl_no_rsp3", rsp_valid32, 0);
    // Two back-to-back loads prove the FIFO is empty again
    set_req(32'h40, 2'd2, 1'b0, 1'b0, 64'h0);
    in_valid32 = 1'b1; addr_ok = 1'b1;
    tick();
    in_addr = 32'h44;
    #1 check("fl_post_req1", req32, 1);
    tick();
    in_valid32 = 1'b0;
    #1 check("fl_post_req2", {req32, req_addr32}, {1'b1, 32'h44});
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 64'h4040_4040;
    tick();
    rdata = 64'h4444_4444;
    #1 check("fl_post_rsp1", {rsp_valid32, rsp_rdata32}, {1'b1, 32'h4040_4040});
    tick();
    data_ok = 1'b0;
    #1 check("fl_post_rsp2", {rsp_valid32, rsp_rdata32}, {1'b1, 32'h4444_4444});
    tick();

    // 64-bit bus
    set_req(32'h208, 2'd3, 1'b1, 1'b0, 64'h0102_0304_0506_0708);
    in_valid64 = 1'b1;
    tick();
    in_valid64 = 1'b0; addr_ok = 1'b1;
    #1 check("d64_std_wstrb", req_wstrb64, 8'hFF);
    check("d64_std_wdata", req_wdata64, 64'h0102_0304_0506_0708);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1;
    tick();
    data_ok = 1'b0;
    #1 check("d64_std_rsp", {rsp_valid64, rsp_wr64, rsp_rdata64}, {2'b11, 64'h0});
    set_req(32'h204, 2'd2, 1'b1, 1'b0, 64'h1122_3344);
    in_valid64 = 1'b1;
    tick();
    in_valid64 = 1'b0; addr_ok = 1'b1;
    #1 check("d64_stw_wstrb", req_wstrb64, 8'hF0);
    check("d64_stw_wdata", req_wdata64, 64'h1122_3344_1122_3344);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1;
    tick();
    data_ok = 1'b0;
    op64("d64_ldw_hi", 32'h204, 2'd2, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0,
         64'h0000_0000_1234_5678);
    op64("d64_ldw_lo", 32'h200, 2'd2, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0,
         64'hFFFF_FFFF_9ABC_DEF0);
    op64("d64_ldd", 32'h208, 2'd3, 1'b0, 1'b0, 64'h8877_6655_4433_2211,
         64'h8877_6655_4433_2211);

    // Reset asserted mid-flight
    set_req(32'h300, 2'd2, 1'b0, 1'b0, 64'h0);
    in_valid64 = 1'b1;
    tick();
    in_addr = 32'h308; addr_ok = 1'b1;
    tick();
    in_valid64 = 1'b0; addr_ok = 1'b0; data_ok = 1'b1; rdata = 64'h55;
    tick();
    data_ok = 1'b0;
    #1 check("mid_pre_rsp", rsp_valid64, 1);
    check("mid_pre_req", req64, 1);
    resetn = 1'b0;
    #1 check("mid_rst_req", req64, 0);
    check("mid_rst_rsp", rsp_valid64, 0);
    check("mid_rst_ready", in_ready64, 1);
    tick();
    resetn = 1'b1;
    data_ok = 1'b1;
    tick();
    data_ok = 1'b0;
    #1 check("post_rst_ignore64", rsp_valid64, 0);
    check("post_rst_ignore32", rsp_valid32, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
